// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - ID/EX pipeline stage register with optional skid entry
//
// Purpose: registers one ID->EX beat (pc, alufn, a, b, d, id) behind a
// valid/ready handshake. With SKID=1 a second entry absorbs the beat that
// arrives while the downstream stalls, so in_ready comes straight from a
// register. With SKID=0 a single entry is used and in_ready is combinational.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - upstream handshake
//   in_pc .. in_id    - upstream payload
//   flush             - drop every held and incoming beat
//   out_valid/out_ready - downstream handshake
//   out_pc .. out_id  - downstream payload (always the main entry)
//   occupancy         - number of held beats (0..2)
//   stall_cnt         - saturating count of out_valid & !out_ready cycles
module pipe_stage_reg #(
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int ALUFN_W = 6,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [ALUFN_W-1:0] in_alufn,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic [DATA_W-1:0]  in_d,
    input  logic [DATA_W-1:0]  in_id,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [ALUFN_W-1:0] out_alufn,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic [DATA_W-1:0]  out_d,
    output logic [DATA_W-1:0]  out_id,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int PW = PC_W + ALUFN_W + 4 * DATA_W;

    // Whole beat travels as one vector so fields can never mix between beats.
    logic [PW-1:0] in_beat;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          main_valid;
    logic          skid_valid;
    logic          in_fire;
    logic          out_fire;

    assign in_beat = {in_pc, in_alufn, in_a, in_b, in_d, in_id};
    assign {out_pc, out_alufn, out_a, out_b, out_d, out_id} = main_q;
    assign out_valid = main_valid;

    // in_ready is forced low during reset; otherwise SKID=1 depends only on
    // the skid valid register, SKID=0 looks through to out_ready.
    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = ~rst & ~skid_valid;
        end else begin : g_ready_single
            assign in_ready = ~rst & (out_ready | ~main_valid);
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            // Flush wins over any handshake in this cycle; payload is left as is.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (SKID != 0) begin
            if (out_fire) begin
                if (skid_valid) begin
                    // Skid advances to main; a same-cycle beat refills skid.
                    main_q     <= skid_q;
                    skid_valid <= in_fire;
                    if (in_fire) begin
                        skid_q <= in_beat;
                    end
                end else begin
                    main_valid <= in_fire;
                    if (in_fire) begin
                        main_q <= in_beat;
                    end
                end
            end else if (in_fire) begin
                if (!main_valid) begin
                    main_valid <= 1'b1;
                    main_q     <= in_beat;
                end else begin
                    skid_valid <= 1'b1;
                    skid_q     <= in_beat;
                end
            end
        end else begin
            skid_valid <= 1'b0;
            if (in_fire) begin
                main_valid <= 1'b1;
                main_q     <= in_beat;
            end else if (out_fire) begin
                main_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_a, in_b, in_d, in_id;
    logic [5:0]  in_alufn;
    logic [31:0] out_pc, out_a, out_b, out_d, out_id;
    logic [5:0]  out_alufn;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [31:0] z_out_pc, z_out_a, z_out_b, z_out_d, z_out_id;
    logic [5:0]  z_out_alufn;
    logic [1:0]  z_occupancy;
    logic [2:0]  z_stall_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_alufn(in_alufn), .in_a(in_a), .in_b(in_b),
        .in_d(in_d), .in_id(in_id), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_alufn(out_alufn),
        .out_a(out_a), .out_b(out_b), .out_d(out_d), .out_id(out_id),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.SKID(0), .CNT_W(3)) dut_single (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_pc(in_pc), .in_alufn(in_alufn), .in_a(in_a), .in_b(in_b),
        .in_d(in_d), .in_id(in_id), .flush(1'b0), .out_valid(z_out_valid),
        .out_ready(z_out_ready), .out_pc(z_out_pc), .out_alufn(z_out_alufn),
        .out_a(z_out_a), .out_b(z_out_b), .out_d(z_out_d), .out_id(z_out_id),
        .occupancy(z_occupancy), .stall_cnt(z_stall_cnt)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] id;
        logic        ev;
        logic [1:0]  eocc;
        logic        erdy;
        logic [31:0] eid;
        logic [15:0] estall;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [31:0] id, input logic ev,
                                input logic [1:0] eocc, input logic erdy,
                                input logic [31:0] eid, input logic [15:0] estall);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.id = id; v.ev = ev;
        v.eocc = eocc; v.erdy = erdy; v.eid = eid; v.estall = estall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_beat(input logic [31:0] pc, input logic [31:0] id);
        in_pc = pc; in_id = id; in_a = ~id; in_b = id + 32'd7;
        in_d = id ^ 32'h5a5a; in_alufn = id[5:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes decided on the falling edge, before the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", {32'h0, out_id}, 64'hffff_ffff);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    chk("sb_id", {32'h0, out_id}, {32'h0, e});
                    chk("sb_a", {32'h0, out_a}, {32'h0, ~e});
                    chk("sb_b", {32'h0, out_b}, {32'h0, e + 32'd7});
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_id);
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        z_in_valid = 1'b0; z_out_ready = 1'b1;
        set_beat(32'h0, 32'h0);

        vecs[0]  = mk(1, 0, 0, 32'hA, 1, 2'd1, 1, 32'hA, 16'd0);
        vecs[1]  = mk(1, 0, 0, 32'hB, 1, 2'd2, 0, 32'hA, 16'd1);
        vecs[2]  = mk(1, 0, 0, 32'hD, 1, 2'd2, 0, 32'hA, 16'd2);
        vecs[3]  = mk(0, 1, 0, 32'h0, 1, 2'd1, 1, 32'hB, 16'd2);
        vecs[4]  = mk(0, 1, 0, 32'h0, 0, 2'd0, 1, 32'h0, 16'd2);
        vecs[5]  = mk(1, 0, 0, 32'h1, 1, 2'd1, 1, 32'h1, 16'd2);
        vecs[6]  = mk(1, 0, 0, 32'h2, 1, 2'd2, 0, 32'h1, 16'd3);
        vecs[7]  = mk(1, 0, 1, 32'hC, 0, 2'd0, 1, 32'h0, 16'd4);
        vecs[8]  = mk(0, 1, 0, 32'h0, 0, 2'd0, 1, 32'h0, 16'd4);
        vecs[9]  = mk(1, 1, 0, 32'h3, 1, 2'd1, 1, 32'h3, 16'd4);
        vecs[10] = mk(1, 1, 0, 32'h4, 1, 2'd1, 1, 32'h4, 16'd4);
        vecs[11] = mk(1, 0, 0, 32'h5, 1, 2'd2, 0, 32'h4, 16'd5);
        vecs[12] = mk(1, 1, 0, 32'h6, 1, 2'd1, 1, 32'h5, 16'd5);
        vecs[13] = mk(0, 1, 0, 32'h0, 0, 2'd0, 1, 32'h0, 16'd5);

        #2;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_occupancy", {62'h0, occupancy}, 64'h0);
        chk("rst_z_in_ready", {63'h0, z_in_ready}, 64'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
        tick;

        for (int i = 0; i < 14; i++) begin
            in_valid = vecs[i].iv; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            set_beat(32'h0, vecs[i].id);
            tick;
            chk($sformatf("vec%0d_out_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].ev});
            chk($sformatf("vec%0d_occupancy", i), {62'h0, occupancy}, {62'h0, vecs[i].eocc});
            chk($sformatf("vec%0d_in_ready", i), {63'h0, in_ready}, {63'h0, vecs[i].erdy});
            chk($sformatf("vec%0d_stall_cnt", i), {48'h0, stall_cnt}, {48'h0, vecs[i].estall});
            if (vecs[i].ev) chk($sformatf("vec%0d_out_id", i), {32'h0, out_id}, {32'h0, vecs[i].eid});
        end
        in_valid = 1'b0; flush = 1'b0;

        // Streaming at full rate.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_beat(32'h100 + 32'(4 * k), 32'h20 + 32'(k));
            tick;
            chk($sformatf("stream%0d_out_pc", k), {32'h0, out_pc}, {32'h0, 32'h100 + 32'(4 * k)});
            chk($sformatf("stream%0d_occupancy", k), {62'h0, occupancy}, 64'h1);
        end
        in_valid = 1'b0;
        tick;
        chk("stream_drain_occupancy", {62'h0, occupancy}, 64'h0);

        // Asynchronous reset with both entries full.
        out_ready = 1'b0; in_valid = 1'b1;
        set_beat(32'h300, 32'h30); tick;
        set_beat(32'h304, 32'h31); tick;
        in_valid = 1'b0;
        chk("arst_pre_occupancy", {62'h0, occupancy}, 64'h2);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_occupancy", {62'h0, occupancy}, 64'h0);
        chk("arst_stall_cnt", {48'h0, stall_cnt}, 64'h0);
        chk("arst_out_pc", {32'h0, out_pc}, 64'h0);
        chk("arst_in_ready", {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("arst_release_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        tick;
        chk("arst_no_partial_beat", {63'h0, out_valid}, 64'h0);

        // Stall counter: 5 stalled edges.
        out_ready = 1'b0; in_valid = 1'b1;
        set_beat(32'h400, 32'h40); tick;
        in_valid = 1'b0;
        repeat (5) tick;
        chk("stall5_cnt", {48'h0, stall_cnt}, 64'd5);
        chk("stall5_hold_id", {32'h0, out_id}, 64'h40);
        out_ready = 1'b1;
        tick;
        chk("stall5_drained", {63'h0, out_valid}, 64'h0);

        // Single-entry variant with a 3-bit saturating counter.
        z_out_ready = 1'b0; z_in_valid = 1'b1;
        set_beat(32'h500, 32'h50); tick;
        chk("single_out_valid", {63'h0, z_out_valid}, 64'h1);
        chk("single_in_ready_comb", {63'h0, z_in_ready}, 64'h0);
        set_beat(32'h504, 32'h51); tick;
        chk("single_occupancy", {62'h0, z_occupancy}, 64'h1);
        chk("single_hold_id", {32'h0, z_out_id}, 64'h50);
        repeat (9) tick;
        chk("single_stall_sat", {61'h0, z_stall_cnt}, 64'd7);
        z_out_ready = 1'b1;
        #1 chk("single_in_ready_open", {63'h0, z_in_ready}, 64'h1);
        tick;
        chk("single_pass_id", {32'h0, z_out_id}, 64'h51);
        chk("single_pass_occupancy", {62'h0, z_occupancy}, 64'h1);
        z_in_valid = 1'b0;
        tick;
        chk("single_empty", {63'h0, z_out_valid}, 64'h0);

        chk("sb_drained", {32'h0, 32'(sb.size())}, 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
